// File: rtl/apb_i2c_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the APB state encoding
// for the APB-to-I2C-engine bridge.
package apb_i2c_pkg;

  localparam int REG_CTRL   = 32'h00;
  localparam int REG_SADDR  = 32'h01;
  localparam int REG_LEN    = 32'h02;
  localparam int REG_TXDATA = 32'h03;
  localparam int REG_RXDATA = 32'h04;
  localparam int REG_STATUS = 32'h05;
  localparam int REG_CMD    = 32'h06;
  localparam int REG_IRQEN  = 32'h07;

  localparam int CTRL_EN = 0;
  localparam int CTRL_RW = 1;

  localparam int ST_TXE  = 0;
  localparam int ST_TXF  = 1;
  localparam int ST_RXE  = 2;
  localparam int ST_RXF  = 3;
  localparam int ST_BUSY = 4;
  localparam int ST_OVF  = 5;
  localparam int ST_NACK = 6;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

endpackage

// File: rtl/apb_i2c_slave_if_if.sv
// APB completer-side bus bundle; the bridge uses the slave modport.
interface apb_i2c_slave_if_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_i2c_slave_if_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int FIFO_D = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DATA_W-1:0]         din_i,
    output logic [DATA_W-1:0]         dout_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(FIFO_D):0]   count_o
);
    localparam int AW = $clog2(FIFO_D);

    logic [DATA_W-1:0] mem_q [FIFO_D];
    logic [AW:0]       wptr_q, rptr_q;
    logic              do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/apb_i2c_slave_if.sv
// APB register front-end for an I2C master engine: TX/RX byte FIFOs and a
// command handshake. Optional feature macro: I2C_IRQ_EN (irq_o + IRQEN reg).
module apb_i2c_slave_if
    import apb_i2c_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    apb_i2c_slave_if_if.slave apb,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [6:0]        cmd_addr_o,
    output logic              cmd_rw_o,
    output logic [DATA_W-1:0] cmd_len_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              done_i,
`ifdef I2C_IRQ_EN
    input  logic              nack_i,
    output logic              irq_o
`else
    input  logic              nack_i
`endif
);
    localparam int CW = $clog2(FIFO_D) + 1;

    apb_state_t        state_q;
    logic              en_q, rw_q, busy_q, ovf_q, nack_q;
    logic [6:0]        saddr_q, cmd_addr_q;
    logic [DATA_W-1:0] len_q, cmd_len_q, prdata_q;
    logic              cmd_valid_q, cmd_rw_q, pready_q, pslverr_q;
`ifdef I2C_IRQ_EN
    logic [2:0]        irqen_q;
    logic              donef_q;
`endif

    logic [31:0]       off;
    logic              acc, wr, rd, go;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d, go_ok;
    logic [7:0]        status;

    logic              tx_push, tx_full, tx_empty, tx_drop;
    logic              rx_pop, rx_full, rx_empty, rx_drop;
    logic [DATA_W-1:0] tx_dout, rx_dout;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic              unused_cnt;

    // Register side effects happen on the SETUP->ACCESS edge.
    assign off = 32'(apb.paddr);
    assign acc = (state_q == SETUP) && apb.psel && apb.penable;
    assign wr  = acc && apb.pwrite;
    assign rd  = acc && !apb.pwrite;
    assign go  = acc && go_ok;

    assign tx_push = wr && (off == REG_TXDATA);
    assign tx_drop = tx_push && tx_full && !tx_ready_i;
    assign rx_pop  = rd && (off == REG_RXDATA);
    assign rx_drop = rx_valid_i && rx_full && !rx_pop;
    assign unused_cnt = ^{tx_cnt, rx_cnt};

    assign status = {1'b0, nack_q, ovf_q, busy_q, rx_full, rx_empty, tx_full, tx_empty};

    sync_fifo #(.DATA_W(DATA_W), .FIFO_D(FIFO_D)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(tx_push), .pop_i(tx_ready_i),
        .din_i(apb.pwdata), .dout_o(tx_dout), .full_o(tx_full),
        .empty_o(tx_empty), .count_o(tx_cnt)
    );

    sync_fifo #(.DATA_W(DATA_W), .FIFO_D(FIFO_D)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(rx_valid_i), .pop_i(rx_pop),
        .din_i(rx_data_i), .dout_o(rx_dout), .full_o(rx_full),
        .empty_o(rx_empty), .count_o(rx_cnt)
    );

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        go_ok   = 1'b0;
        case (off)
            REG_CTRL:   rdata_d = DATA_W'({rw_q, en_q});
            REG_SADDR:  rdata_d = DATA_W'(saddr_q);
            REG_LEN:    rdata_d = len_q;
            REG_TXDATA: err_d = apb.pwrite && tx_full && !tx_ready_i;
            REG_RXDATA: begin
                if (!apb.pwrite) begin
                    if (rx_empty) err_d = 1'b1;
                    else          rdata_d = rx_dout;
                end
            end
            REG_STATUS: rdata_d = DATA_W'(status);
            REG_CMD: begin
                if (apb.pwrite && apb.pwdata[0]) begin
                    if (en_q && !busy_q) go_ok = 1'b1;
                    else                 err_d = 1'b1;
                end
            end
`ifdef I2C_IRQ_EN
            REG_IRQEN:  rdata_d = DATA_W'({donef_q, 1'b0, irqen_q});
`endif
            default:    err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            en_q        <= 1'b0;
            rw_q        <= 1'b0;
            saddr_q     <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            nack_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_rw_q    <= 1'b0;
            cmd_len_q   <= '0;
`ifdef I2C_IRQ_EN
            irqen_q     <= '0;
            donef_q     <= 1'b0;
`endif
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            case (state_q)
                IDLE:   if (apb.psel && !apb.penable) state_q <= SETUP;
                SETUP: begin
                    if (!apb.psel) begin
                        state_q <= IDLE;
                    end else if (apb.penable) begin
                        state_q   <= ACCESS;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_d;
                        prdata_q  <= apb.pwrite ? '0 : rdata_d;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // W1C clears come first so a same-cycle set wins.
            if (wr) begin
                case (off)
                    REG_CTRL:   {rw_q, en_q} <= apb.pwdata[1:0];
                    REG_SADDR:  saddr_q <= apb.pwdata[6:0];
                    REG_LEN:    len_q   <= apb.pwdata;
                    REG_STATUS: begin
                        if (apb.pwdata[ST_OVF])  ovf_q  <= 1'b0;
                        if (apb.pwdata[ST_NACK]) nack_q <= 1'b0;
                    end
`ifdef I2C_IRQ_EN
                    REG_IRQEN: begin
                        irqen_q <= apb.pwdata[2:0];
                        if (apb.pwdata[4]) donef_q <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end

            if (cmd_valid_q && cmd_ready_i) cmd_valid_q <= 1'b0;
            if (done_i) begin
                busy_q      <= 1'b0;
                cmd_valid_q <= 1'b0;
                if (nack_i) nack_q <= 1'b1;
`ifdef I2C_IRQ_EN
                donef_q <= 1'b1;
`endif
            end
            if (go) begin
                cmd_valid_q <= 1'b1;
                busy_q      <= 1'b1;
                cmd_addr_q  <= saddr_q;
                cmd_rw_q    <= rw_q;
                cmd_len_q   <= len_q;
            end
            if (tx_drop || rx_drop) ovf_q <= 1'b1;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_addr_o  = cmd_addr_q;
    assign cmd_rw_o    = cmd_rw_q;
    assign cmd_len_o   = cmd_len_q;
    assign tx_valid_o  = !tx_empty;
    assign tx_data_o   = tx_dout;
`ifdef I2C_IRQ_EN
    assign irq_o = (irqen_q[0] & donef_q) | (irqen_q[1] & ovf_q) | (irqen_q[2] & nack_q);
`endif
endmodule
